// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin arbiter for the register file write port
// Two per-requester FIFOs feed one registered write port; PEND flags queued or in-flight writes.
module regfile_wr_arbiter #(
   parameter int DW    = 32,
   parameter int AW    = 5,
   parameter int DEPTH = 2
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          REQ0_VALID,
   output logic          REQ0_READY,
   input  logic [AW-1:0] REQ0_A,
   input  logic [DW-1:0] REQ0_WD,
   input  logic          REQ1_VALID,
   output logic          REQ1_READY,
   input  logic [AW-1:0] REQ1_A,
   input  logic [DW-1:0] REQ1_WD,
   output logic          WE3,
   output logic [AW-1:0] A3,
   output logic [DW-1:0] WD3,
   output logic [31:0]   PEND
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [AW-1:0] r_fa [2][DEPTH];
   logic [DW-1:0] r_fd [2][DEPTH];
   logic [PW-1:0] r_wp [2];
   logic [PW-1:0] r_rp [2];
   logic [CW-1:0] r_cnt [2];
   logic          r_last;

   logic [1:0]    w_valid, w_ready, w_push, w_pop, w_ne;
   logic [AW-1:0] w_in_a [2];
   logic [DW-1:0] w_in_d [2];
   logic          w_gnt, w_sel;
   logic [31:0]   w_pend;

   assign w_valid   = {REQ1_VALID, REQ0_VALID};
   assign w_in_a[0] = REQ0_A;
   assign w_in_a[1] = REQ1_A;
   assign w_in_d[0] = REQ0_WD;
   assign w_in_d[1] = REQ1_WD;

   // Address-0 writes complete the handshake but never occupy a slot.
   always_comb begin
      w_ready = '0;
      w_ne    = '0;
      w_push  = '0;
      for (int i = 0; i < 2; i++) begin
         w_ready[i] = (r_cnt[i] != FULL);
         w_ne[i]    = (r_cnt[i] != '0);
         w_push[i]  = w_valid[i] && w_ready[i] && (w_in_a[i] != '0);
      end
   end

   assign REQ0_READY = w_ready[0];
   assign REQ1_READY = w_ready[1];

   assign w_gnt = |w_ne;
   assign w_sel = (&w_ne) ? ~r_last : w_ne[1];
   assign w_pop = w_gnt ? (w_sel ? 2'b10 : 2'b01) : 2'b00;

   always_ff @(posedge CLK) begin
      for (int i = 0; i < 2; i++) begin
         if (w_push[i]) begin
            r_fa[i][r_wp[i]] <= w_in_a[i];
            r_fd[i][r_wp[i]] <= w_in_d[i];
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < 2; i++) begin
            r_wp[i]  <= '0;
            r_rp[i]  <= '0;
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (w_push[i]) r_wp[i] <= r_wp[i] + PW'(1);
            if (w_pop[i])  r_rp[i] <= r_rp[i] + PW'(1);
            r_cnt[i] <= r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         WE3    <= 1'b0;
         A3     <= '0;
         WD3    <= '0;
         r_last <= 1'b1;
      end else if (w_gnt) begin
         WE3    <= 1'b1;
         A3     <= r_fa[w_sel][r_rp[w_sel]];
         WD3    <= r_fd[w_sel][r_rp[w_sel]];
         r_last <= w_sel;
      end else begin
         WE3    <= 1'b0;
      end
   end

   // OR of every occupied slot plus the write port, so duplicates need no counters.
   always_comb begin
      w_pend = '0;
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < r_cnt[i]) w_pend[r_fa[i][r_rp[i] + PW'(k)]] = 1'b1;
         end
      end
      if (WE3) w_pend[A3] = 1'b1;
   end

   assign PEND = w_pend;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - directed and random checks of regfile_wr_arbiter against a queue model
module tb_regfile_wr_arbiter;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 2;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
   logic [AW-1:0] REQ0_A = '0, REQ1_A = '0;
   logic [DW-1:0] REQ0_WD = '0, REQ1_WD = '0;
   logic          REQ0_READY, REQ1_READY, WE3;
   logic [AW-1:0] A3;
   logic [DW-1:0] WD3;
   logic [31:0]   PEND;

   regfile_wr_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST(RST),
      .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_A(REQ0_A), .REQ0_WD(REQ0_WD),
      .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_A(REQ1_A), .REQ1_WD(REQ1_WD),
      .WE3(WE3), .A3(A3), .WD3(WD3), .PEND(PEND)
   );

   always #5 CLK = ~CLK;

   ent_t          mq0[$], mq1[$];
   bit            m_last;
   logic          m_we;
   logic [AW-1:0] m_a;
   logic [DW-1:0] m_wd;
   int            n_assert = 0;
   int            n_fail = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_pend();
      logic [31:0] p = '0;
      foreach (mq0[i]) p[mq0[i].a] = 1'b1;
      foreach (mq1[i]) p[mq1[i].a] = 1'b1;
      if (m_we) p[m_a] = 1'b1;
      return p;
   endfunction

   task automatic model_reset();
      mq0.delete();
      mq1.delete();
      m_last = 1'b1;
      m_we   = 1'b0;
      m_a    = '0;
      m_wd   = '0;
   endtask

   // One clock: drive at posedge+1, check ready, advance the model, check outputs at next posedge+1.
   task automatic step(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       output logic acc0, output logic acc1);
      bit   r0, r1, ne0, ne1, g;
      ent_t e;
      REQ0_VALID = v0; REQ0_A = a0; REQ0_WD = d0;
      REQ1_VALID = v1; REQ1_A = a1; REQ1_WD = d1;
      #1;
      r0 = (mq0.size() != DEPTH);
      r1 = (mq1.size() != DEPTH);
      check("ready0", REQ0_READY, r0);
      check("ready1", REQ1_READY, r1);
      acc0 = v0 && r0;
      acc1 = v1 && r1;
      ne0 = (mq0.size() != 0);
      ne1 = (mq1.size() != 0);
      if (ne0 || ne1) begin
         g = (ne0 && ne1) ? !m_last : ne1;
         e = g ? mq1.pop_front() : mq0.pop_front();
         m_we = 1'b1; m_a = e.a; m_wd = e.d; m_last = g;
      end else begin
         m_we = 1'b0;
      end
      if (acc0 && a0 != 0) mq0.push_back('{a: a0, d: d0});
      if (acc1 && a1 != 0) mq1.push_back('{a: a1, d: d1});
      @(posedge CLK);
      #1;
      check("we3", WE3, m_we);
      check("a3", A3, m_a);
      check("wd3", WD3, m_wd);
      check("pend", PEND, exp_pend());
   endtask

   task automatic idle(input int n);
      logic x0, x1;
      for (int c = 0; c < n; c++) step(0, '0, '0, 0, '0, '0, x0, x1);
   endtask

   task automatic stream(input int n0, input int n1, input int b0, input int b1, input int max_cyc);
      int   k0 = 0, k1 = 0;
      logic c0, c1;
      for (int c = 0; c < max_cyc && (k0 < n0 || k1 < n1); c++) begin
         step(k0 < n0, AW'(b0 + k0), 32'hA000_0000 + k0,
              k1 < n1, AW'(b1 + k1), 32'hB000_0000 + k1, c0, c1);
         if (c0) k0++;
         if (c1) k1++;
      end
      check("stream_cnt0", k0, n0);
      check("stream_cnt1", k1, n1);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_we3"}, WE3, 1'b0);
      check({tag, "_a3"}, A3, '0);
      check({tag, "_wd3"}, WD3, '0);
      check({tag, "_pend"}, PEND, '0);
      check({tag, "_rdy0"}, REQ0_READY, 1'b1);
      check({tag, "_rdy1"}, REQ1_READY, 1'b1);
   endtask

   initial begin
      logic c0, c1;
      model_reset();
      #1 RST = 1'b1;
      #1 check_reset_state("reset");
      #10 RST = 1'b0;
      @(posedge CLK);
      #1;

      // Single write to r5: on the port after the second edge.
      step(1, 5'd5, 32'hDEAD_BEEF, 0, '0, '0, c0, c1);
      check("single_pend5_early", PEND[5], 1'b1);
      check("single_we_early", WE3, 1'b0);
      step(0, '0, '0, 0, '0, '0, c0, c1);
      check("single_we", WE3, 1'b1);
      check("single_a3", A3, 5'd5);
      check("single_wd3", WD3, 32'hDEAD_BEEF);
      step(0, '0, '0, 0, '0, '0, c0, c1);
      check("single_pend5_clear", PEND[5], 1'b0);

      // Address 0 is accepted and discarded.
      step(0, '0, '0, 1, 5'd0, 32'h1234, c0, c1);
      check("r0_acc", c1, 1'b1);
      idle(2);

      // Contention, then backpressure on requester 0 while requester 1 bursts.
      stream(6, 6, 1, 17, 40);
      idle(4);
      stream(3, 5, 2, 20, 40);
      idle(8);

      // Duplicate pending on r7.
      step(1, 5'd7, 32'h0000_AAAA, 0, '0, '0, c0, c1);
      step(0, '0, '0, 1, 5'd7, 32'h0000_BBBB, c0, c1);
      idle(4);

      // Fill both FIFOs with a write on the port, then reset between edges.
      for (int c = 0; c < 5; c++) step(1, 5'd3, 32'h3300 + c, 1, 5'd9, 32'h9900 + c, c0, c1);
      check("pre_rst_we3", WE3, 1'b1);
      REQ0_VALID = 0;
      REQ1_VALID = 0;
      #3 RST = 1'b1;
      #1 check_reset_state("midrst");
      model_reset();
      @(posedge CLK);
      #1 RST = 1'b0;
      idle(3);

      for (int c = 0; c < 400; c++) begin
         step($urandom_range(0, 3) != 0, AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31)), $urandom,
              $urandom_range(0, 3) != 0, AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31)), $urandom,
              c0, c1);
      end
      idle(6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
